// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, bit-timing helper and frame width.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs (serial lines, buttons).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid / framing-error strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 busy_o
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t          state, state_next;
  logic                 rxs, rxs_d;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, fall;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxs_d <= 1'b1;
    else        rxs_d <= rxs;
  end

  // Only a high-to-low transition starts a frame, so a stuck-low line never retriggers.
  assign fall = rxs_d & ~rxs;
  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fall) state_next = START;
      START:  if (tick) state_next = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (tick && bit_idx == 3'(DATA_BITS - 1)) state_next = PARITY;
      PARITY: if (tick) state_next = STOP;
`else
      DATA:   if (tick && bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
`endif
      STOP:   if (tick) state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      case (state)
        IDLE: if (fall) cnt <= HALF_LOAD;
        START: begin
          if (tick) begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt     <= FULL_LOAD;
            shreg   <= {rxs, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            cnt     <= FULL_LOAD;
            par_bit <= rxs;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          // Return to IDLE at mid-stop so a following start bit is caught without a gap.
          if (tick) begin
            if (!rxs) begin
              frame_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (^{shreg, par_bit}) begin
              parity_err_o <= 1'b1;
`endif
            end else begin
              data_o  <= shreg;
              valid_o <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
// Build with UART_RX_PARITY_EN to also exercise the parity path.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int C        = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i  = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, busy_o;
  logic       parity_err_o;
`ifndef UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .frame_err_o  (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (parity_err_o),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Monitor: counts strobes and logs every accepted byte, sampled on the falling edge.
  int         mon_valid = 0, mon_ferr = 0, mon_perr = 0, mon_both = 0, mon_wide = 0;
  logic [7:0] mon_data[$];
  time        t_valid = 0, t_fall = 0;
  logic       prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        mon_valid <= mon_valid + 1;
        mon_data.push_back(data_o);
        if (!prev_v) t_valid <= $time;
      end
      if (frame_err_o)  mon_ferr <= mon_ferr + 1;
      if (parity_err_o) mon_perr <= mon_perr + 1;
      if ((valid_o && frame_err_o) || (valid_o && parity_err_o) || (frame_err_o && parity_err_o))
        mon_both <= mon_both + 1;
      if ((valid_o && prev_v) || (frame_err_o && prev_f) || (parity_err_o && prev_p))
        mon_wide <= mon_wide + 1;
      prev_v <= valid_o;
      prev_f <= frame_err_o;
      prev_p <= parity_err_o;
    end else begin
      prev_v <= 1'b0;
      prev_f <= 1'b0;
      prev_p <= 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (C) @(negedge clk);
  endtask

  // Ideal frame: start, 8 data bits LSB first, optional even parity (flip corrupts it), stop.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    t_fall = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ flip);
    drive_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy_o !== 1'b0 && k < 20 * C) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_idle_timeout: busy_o=%b required 0", tag, busy_o);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (data_o !== 8'h00)     begin n_mis++; $display("FAIL reset_data: got %h required 00", data_o); end
    n_cmp++; if (valid_o !== 1'b0)     begin n_mis++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    n_cmp++; if (frame_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_frame_err: got %b required 0", frame_err_o); end
    n_cmp++; if (busy_o !== 1'b0)      begin n_mis++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    n_cmp++; if (parity_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_parity_err: got %b required 0", parity_err_o); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int  v0, f0;
    time lat;
    v0 = mon_valid; f0 = mon_ferr;
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_idle("basic");
    n_cmp++; if (mon_valid - v0 !== 1) begin n_mis++; $display("FAIL basic_valid_count: got %0d required 1", mon_valid - v0); end
    n_cmp++; if (data_o !== 8'hA5)     begin n_mis++; $display("FAIL basic_data: got %h required a5", data_o); end
    n_cmp++; if (mon_ferr - f0 !== 0)  begin n_mis++; $display("FAIL basic_frame_err: got %0d pulses required 0", mon_ferr - f0); end
    lat = (t_valid - t_fall) / 10;
    n_cmp++;
    if (lat < time'(3 + C / 2 + 9 * C - 1) || lat > time'(3 + C / 2 + 9 * C + 1)) begin
      n_mis++;
      $display("FAIL basic_latency: got %0d cycles required %0d +/-1", lat, 3 + C / 2 + 9 * C);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = mon_valid;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_idle("b2b");
    n_cmp++;
    if (mon_valid - v0 !== 2) begin
      n_mis++; $display("FAIL b2b_valid_count: got %0d required 2", mon_valid - v0);
    end else begin
      n_cmp++; if (mon_data[v0] !== 8'h00)     begin n_mis++; $display("FAIL b2b_first: got %h required 00", mon_data[v0]); end
      n_cmp++; if (mon_data[v0 + 1] !== 8'hFF) begin n_mis++; $display("FAIL b2b_second: got %h required ff", mon_data[v0 + 1]); end
    end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = mon_valid; f0 = mon_ferr;
    rx_i = 1'b0;
    repeat (C / 8) @(negedge clk);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL glitch_busy_start: got %b required 1", busy_o); end
    wait_idle("glitch");
    n_cmp++; if (mon_valid - v0 !== 0 || mon_ferr - f0 !== 0) begin
      n_mis++; $display("FAIL glitch_strobes: got valid=%0d ferr=%0d required 0/0", mon_valid - v0, mon_ferr - f0);
    end
    n_cmp++; if (data_o !== 8'hFF) begin n_mis++; $display("FAIL glitch_data_held: got %h required ff", data_o); end
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_idle("glitch_next");
    n_cmp++; if (mon_valid - v0 !== 1 || data_o !== 8'h3C) begin
      n_mis++; $display("FAIL glitch_next_byte: got count=%0d data=%h required 1/3c", mon_valid - v0, data_o);
    end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = mon_valid; f0 = mon_ferr;
    send_frame(8'h55, 1'b0, 1'b0);
    rx_i = 1'b0;
    repeat (20 * C) @(negedge clk);
    n_cmp++; if (mon_ferr - f0 !== 1)  begin n_mis++; $display("FAIL ferr_count: got %0d required 1", mon_ferr - f0); end
    n_cmp++; if (mon_valid - v0 !== 0) begin n_mis++; $display("FAIL ferr_valid: got %0d required 0", mon_valid - v0); end
    n_cmp++; if (data_o !== 8'h3C)     begin n_mis++; $display("FAIL ferr_data_held: got %h required 3c", data_o); end
    n_cmp++; if (busy_o !== 1'b0)      begin n_mis++; $display("FAIL ferr_no_retrigger: busy_o=%b required 0", busy_o); end
    rx_i = 1'b1;
    repeat (2 * C) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_idle("ferr_next");
    n_cmp++; if (mon_valid - v0 !== 1 || data_o !== 8'h81) begin
      n_mis++; $display("FAIL ferr_next_byte: got count=%0d data=%h required 1/81", mon_valid - v0, data_o);
    end
  endtask

  task automatic test_reset_midframe;
    int         v0, f0;
    logic [7:0] d;
    d = 8'h7E;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_i = d[4];
    repeat (C / 2) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL rst_busy_before: got %b required 1", busy_o); end
    v0 = mon_valid; f0 = mon_ferr;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (data_o !== 8'h00) begin n_mis++; $display("FAIL rst_async_data: got %h required 00", data_o); end
    n_cmp++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
      n_mis++; $display("FAIL rst_async_ctrl: busy=%b valid=%b ferr=%b required 0/0/0", busy_o, valid_o, frame_err_o);
    end
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * C) @(negedge clk);
    n_cmp++; if (mon_valid - v0 !== 0 || mon_ferr - f0 !== 0) begin
      n_mis++; $display("FAIL rst_abort_strobes: got valid=%0d ferr=%0d required 0/0", mon_valid - v0, mon_ferr - f0);
    end
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_idle("rst_next");
    n_cmp++; if (mon_valid - v0 !== 1 || data_o !== 8'h7E) begin
      n_mis++; $display("FAIL rst_next_byte: got count=%0d data=%h required 1/7e", mon_valid - v0, data_o);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, f0, p0;
    v0 = mon_valid; f0 = mon_ferr; p0 = mon_perr;
    send_frame(8'h03, 1'b1, 1'b1);
    wait_idle("par_bad");
    n_cmp++; if (mon_perr - p0 !== 1 || mon_valid - v0 !== 0) begin
      n_mis++; $display("FAIL par_bad: got perr=%0d valid=%0d required 1/0", mon_perr - p0, mon_valid - v0);
    end
    n_cmp++; if (data_o !== 8'h7E) begin n_mis++; $display("FAIL par_bad_data_held: got %h required 7e", data_o); end
    send_frame(8'h03, 1'b1, 1'b0);
    wait_idle("par_good");
    n_cmp++; if (mon_valid - v0 !== 1 || data_o !== 8'h03) begin
      n_mis++; $display("FAIL par_good: got count=%0d data=%h required 1/03", mon_valid - v0, data_o);
    end
    p0 = mon_perr; f0 = mon_ferr;
    send_frame(8'h03, 1'b0, 1'b1);
    repeat (C) @(negedge clk);
    rx_i = 1'b1;
    wait_idle("par_ferr");
    n_cmp++; if (mon_ferr - f0 !== 1 || mon_perr - p0 !== 0) begin
      n_mis++; $display("FAIL par_ferr_precedence: got ferr=%0d perr=%0d required 1/0", mon_ferr - f0, mon_perr - p0);
    end
  endtask
`endif

  task automatic test_random;
    int         v0, f0, p0, exp_f, exp_p, gap;
    logic [7:0] exp_q[$];
    logic [7:0] d, exp_last;
    logic       stop, flip;
    v0 = mon_valid; f0 = mon_ferr; p0 = mon_perr;
    exp_f = 0; exp_p = 0;
    exp_last = data_o;
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      flip = PAR_EN && ($urandom_range(0, 4) == 0);
      if (!stop)     exp_f++;
      else if (flip) exp_p++;
      else begin
        exp_q.push_back(d);
        exp_last = d;
      end
      send_frame(d, stop, flip);
      // A rejected stop bit leaves the line low, so a high gap is needed before the next start edge.
      gap = stop ? $urandom_range(0, C) : $urandom_range(C / 4, C);
      repeat (gap) @(negedge clk);
    end
    wait_idle("rand");
    n_cmp++; if (mon_ferr - f0 !== exp_f) begin n_mis++; $display("FAIL rand_ferr_count: got %0d required %0d", mon_ferr - f0, exp_f); end
    n_cmp++; if (mon_perr - p0 !== exp_p) begin n_mis++; $display("FAIL rand_perr_count: got %0d required %0d", mon_perr - p0, exp_p); end
    n_cmp++;
    if (mon_valid - v0 !== exp_q.size()) begin
      n_mis++; $display("FAIL rand_valid_count: got %0d required %0d", mon_valid - v0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (mon_data[v0 + i] !== exp_q[i]) begin
          n_mis++; $display("FAIL rand_byte_%0d: got %h required %h", i, mon_data[v0 + i], exp_q[i]);
        end
      end
    end
    n_cmp++; if (data_o !== exp_last) begin n_mis++; $display("FAIL rand_data_hold: got %h required %h", data_o, exp_last); end
  endtask

  task automatic test_invariants;
    n_cmp++; if (mon_both !== 0) begin n_mis++; $display("FAIL strobe_overlap: got %0d cycles required 0", mon_both); end
    n_cmp++; if (mon_wide !== 0) begin n_mis++; $display("FAIL strobe_width: got %0d wide pulses required 0", mon_wide); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_random;
    test_invariants;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
